lbm_dist_bank: RTL and testbench



---
 rtl/lbm_pkg.sv | 28 ++
 rtl/dp_ram_1r1w.sv | 37 +++
 rtl/lbm_dist_bank.sv | 191 +++++++++++++++++++
 tb/tb_lbm_dist_bank.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_pkg.sv
// rtl/lbm_pkg.sv - shared constants and state encoding for the LBM distribution bank
//
// Purpose: D2Q9 direction indices (fix the channel order of every flattened bus),
//          default word width and the bank controller state encoding.
// Ports:   none (package).
package lbm_pkg;

    localparam int N_DIR  = 9;
    localparam int DATA_W = 16;

    // Channel c of every flattened bus carries direction c below.
    localparam int C0 = 0;
    localparam int N  = 1;
    localparam int NE = 2;
    localparam int E  = 3;
    localparam int SE = 4;
    localparam int S  = 5;
    localparam int SW = 6;
    localparam int W  = 7;
    localparam int NW = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } lbm_state_e;

endpackage

// File: rtl/dp_ram_1r1w.sv
// rtl/dp_ram_1r1w.sv - simple dual-port RAM, one write port and one registered read port
//
// Purpose: storage for one bank of one distribution channel. Contents are not
//          reset; callers guarantee addresses are below DEPTH.
// Ports:   clk                        clock
//          wr_en / wr_addr / wr_data  synchronous write
//          rd_en / rd_addr            read request, data returned next cycle
//          rd_data                    registered read data (holds when rd_en low)
module dp_ram_1r1w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lbm_dist_bank.sv
// rtl/lbm_dist_bank.sv - ping-pong current/next storage for LBM distribution functions
//
// Purpose: N_CH channels, each with two DEPTH-deep banks. The solver reads the
//          current bank and writes the next bank; swap_req flips the roles at the
//          end of a time step. After reset (or fill_start in IDLE) both banks of
//          every channel are filled with init_val before the block reports ready.
// Ports:   clk, rst (synchronous, active low)
//          init_val                       per-channel fill value
//          fill_start, run                FSM control (IDLE -> FILL / RUN)
//          rd_en, rd_addr                 read request into the current bank
//          rd_data, rd_valid, rd_bank     registered read response + bank tag
//          wr_en, wr_addr, wr_data        per-channel writes into the next bank
//          swap_req, swap_ack             step boundary handshake
//          cur_bank, step_count           bank roles and completed swaps
//          ready, err_oob                 IDLE/RUN indicator, sticky range error
module lbm_dist_bank #(
    parameter int N_CH   = lbm_pkg::N_DIR,
    parameter int DATA_W = lbm_pkg::DATA_W,
    parameter int DEPTH  = 2500,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   init_val,
    input  logic                     fill_start,
    input  logic                     run,
    input  logic                     rd_en,
    input  logic [N_CH*ADDR_W-1:0]   rd_addr,
    output logic [N_CH*DATA_W-1:0]   rd_data,
    output logic                     rd_valid,
    output logic                     rd_bank,
    input  logic [N_CH-1:0]          wr_en,
    input  logic [N_CH*ADDR_W-1:0]   wr_addr,
    input  logic [N_CH*DATA_W-1:0]   wr_data,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     cur_bank,
    output logic [31:0]              step_count,
    output logic                     ready,
    output logic                     err_oob
);

    import lbm_pkg::*;

    // RAM address width: ADDR_W may be wider than needed so that out-of-range
    // addresses are representable; only the low MEM_AW bits reach the RAMs.
    localparam int                MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [MEM_AW-1:0] FILL_LAST = MEM_AW'(DEPTH - 1);

    lbm_state_e        state;
    logic [MEM_AW-1:0] fill_addr;

    logic              filling;
    logic              rd_accept;
    logic              wr_active;
    logic              swap_fire;
    logic [N_CH-1:0]   rd_oob;
    logic [N_CH-1:0]   wr_oob;
    logic [N_CH-1:0]   wr_ok;
    // Per-channel flag forcing rd_data to zero (reset value and out-of-range reads).
    logic [N_CH-1:0]   rd_zero;

    assign filling   = (state == ST_FILL);
    assign rd_accept = rd_en && !filling;
    assign wr_active = (state == ST_RUN);
    assign swap_fire = (state == ST_RUN) && swap_req;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] q0;
        logic [DATA_W-1:0] q1;
        logic              we0;
        logic              we1;
        logic [MEM_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;

        assign ra = rd_addr[c*ADDR_W +: ADDR_W];
        assign wa = wr_addr[c*ADDR_W +: ADDR_W];

        assign rd_oob[c] = ({1'b0, ra} >= DEPTH_X);
        assign wr_oob[c] = ({1'b0, wa} >= DEPTH_X);
        assign wr_ok[c]  = wr_active && wr_en[c] && !wr_oob[c];

        // The fill drives both banks at once; otherwise only the next bank
        // (the one not designated current) accepts solver writes.
        assign we0   = filling || (wr_ok[c] &&  cur_bank);
        assign we1   = filling || (wr_ok[c] && !cur_bank);
        assign waddr = filling ? fill_addr : wa[MEM_AW-1:0];
        assign wdata = filling ? init_val[c*DATA_W +: DATA_W]
                               : wr_data[c*DATA_W +: DATA_W];

        dp_ram_1r1w #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (MEM_AW)
        ) u_bank0 (
            .clk     (clk),
            .wr_en   (we0),
            .wr_addr (waddr),
            .wr_data (wdata),
            .rd_en   (rd_accept),
            .rd_addr (ra[MEM_AW-1:0]),
            .rd_data (q0)
        );

        dp_ram_1r1w #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (MEM_AW)
        ) u_bank1 (
            .clk     (clk),
            .wr_en   (we1),
            .wr_addr (waddr),
            .wr_data (wdata),
            .rd_en   (rd_accept),
            .rd_addr (ra[MEM_AW-1:0]),
            .rd_data (q1)
        );

        // Both banks are read every accepted cycle; rd_bank (the cur_bank
        // captured at issue) picks the one that was current at that time.
        assign rd_data[c*DATA_W +: DATA_W] = rd_zero[c] ? '0 : (rd_bank ? q1 : q0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FILL;
            fill_addr  <= '0;
            cur_bank   <= 1'b0;
            step_count <= 32'd0;
            rd_valid   <= 1'b0;
            rd_bank    <= 1'b0;
            rd_zero    <= '1;
            swap_ack   <= 1'b0;
            ready      <= 1'b0;
            err_oob    <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            swap_ack <= swap_fire;

            if (rd_accept) begin
                rd_bank <= cur_bank;
                rd_zero <= rd_oob;
            end

            // Writes in the swap cycle already used the old cur_bank above,
            // so they land in the bank that becomes current after this edge.
            if (swap_fire) begin
                cur_bank   <= ~cur_bank;
                step_count <= step_count + 32'd1;
            end

            if ((rd_accept && |rd_oob) || (wr_active && |(wr_en & wr_oob))) begin
                err_oob <= 1'b1;
            end

            case (state)
                ST_FILL: begin
                    if (fill_addr == FILL_LAST) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        fill_addr <= fill_addr + MEM_AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (fill_start) begin
                        state     <= ST_FILL;
                        fill_addr <= '0;
                        ready     <= 1'b0;
                    end else if (run) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_FILL;
                    fill_addr <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_dist_bank.sv
// tb/tb_lbm_dist_bank.sv - self-checking bench for lbm_dist_bank (N_CH=9, DEPTH=16)
module tb_lbm_dist_bank;

    import lbm_pkg::*;

    localparam int NC = 9;
    localparam int DW = 16;
    localparam int DP = 16;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*DW-1:0]  init_val;
    logic              fill_start;
    logic              run;
    logic              rd_en;
    logic [NC*AW-1:0]  rd_addr;
    logic [NC*DW-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_bank;
    logic [NC-1:0]     wr_en;
    logic [NC*AW-1:0]  wr_addr;
    logic [NC*DW-1:0]  wr_data;
    logic              swap_req;
    logic              swap_ack;
    logic              cur_bank;
    logic [31:0]       step_count;
    logic              ready;
    logic              err_oob;

    lbm_dist_bank #(
        .N_CH   (NC),
        .DATA_W (DW),
        .DEPTH  (DP),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_val   (init_val),
        .fill_start (fill_start),
        .run        (run),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_bank    (rd_bank),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .cur_bank   (cur_bank),
        .step_count (step_count),
        .ready      (ready),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents of both banks, bank roles, swap count, error flag.
    logic [DW-1:0] m_mem [2][NC][DP];
    int            m_cur;
    int unsigned   m_steps;
    bit            m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rd_en      = 1'b0;
        wr_en      = '0;
        swap_req   = 1'b0;
        fill_start = 1'b0;
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
    endtask

    task automatic set_init(input int base);
        for (int c = 0; c < NC; c++) init_val[c*DW +: DW] = DW'(base + c);
    endtask

    task automatic model_fill();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < NC; c++)
                for (int a = 0; a < DP; a++)
                    m_mem[b][c][a] = init_val[c*DW +: DW];
    endtask

    task automatic set_rd_all(input int a);
        rd_en = 1'b1;
        for (int c = 0; c < NC; c++) rd_addr[c*AW +: AW] = AW'(a);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 100);
        check(tag, n, 16);
    endtask

    // Predict this cycle from the model, advance one clock, compare everything.
    task automatic step_and_check(input bit in_run);
        logic [DW-1:0] exp_d [NC];
        bit            exp_v;
        int            exp_b;
        bit            exp_ack;
        int            a;
        int            nb;
        exp_v = rd_en;
        exp_b = m_cur;
        for (int c = 0; c < NC; c++) begin
            a = int'(rd_addr[c*AW +: AW]);
            if (a >= DP) begin
                exp_d[c] = '0;
                if (rd_en) m_err = 1'b1;
            end else begin
                exp_d[c] = m_mem[m_cur][c][a];
            end
        end
        nb = 1 - m_cur;
        if (in_run) begin
            for (int c = 0; c < NC; c++) begin
                if (wr_en[c]) begin
                    a = int'(wr_addr[c*AW +: AW]);
                    if (a >= DP) m_err = 1'b1;
                    else m_mem[nb][c][a] = wr_data[c*DW +: DW];
                end
            end
        end
        exp_ack = in_run && swap_req;
        if (exp_ack) begin
            m_cur   = nb;
            m_steps = m_steps + 1;
        end
        tick();
        check("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            check("rd_bank", rd_bank, exp_b);
            for (int c = 0; c < NC; c++)
                check($sformatf("rd_data[%0d]", c), rd_data[c*DW +: DW], exp_d[c]);
        end
        check("cur_bank", cur_bank, m_cur);
        check("step_count", step_count, m_steps);
        check("swap_ack", swap_ack, exp_ack);
        check("err_oob", err_oob, m_err);
        check("ready", ready, 1);
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        clr_in();
        set_init(16'h0100);
        m_cur = 0; m_steps = 0; m_err = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ready", ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_rd_data", rd_data[31:0], 0);
        check("rst_cur_bank", cur_bank, 0);
        check("rst_step_count", step_count, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_err_oob", err_oob, 0);

        rst = 1'b1;
        wait_ready("fill_cycles");
        model_fill();

        // Dump every address of the current bank from IDLE
        for (int a = 0; a < DP; a++) begin
            set_rd_all(a);
            step_and_check(1'b0);
        end
        check("dump_ch8_lit", rd_data[8*DW +: DW], 16'h0108);
        clr_in();

        // Enter RUN, write goes to next bank
        run = 1'b1;
        step_and_check(1'b0);
        wr_en[E] = 1'b1;
        wr_addr[E*AW +: AW] = 5'd5;
        wr_data[E*DW +: DW] = 16'h1234;
        step_and_check(1'b1);
        clr_in();
        rd_en = 1'b1;
        rd_addr[E*AW +: AW] = 5'd5;
        step_and_check(1'b1);
        check("pre_swap_lit", rd_data[E*DW +: DW], 16'h0103);
        clr_in();
        swap_req = 1'b1;
        step_and_check(1'b1);
        check("swap_cur_lit", cur_bank, 1);
        check("swap_cnt_lit", step_count, 1);
        check("swap_ack_lit", swap_ack, 1);
        clr_in();
        rd_en = 1'b1;
        rd_addr[E*AW +: AW] = 5'd5;
        step_and_check(1'b1);
        check("post_swap_lit", rd_data[E*DW +: DW], 16'h1234);
        check("post_swap_bank", rd_bank, 1);

        // Read and write issued in the swap cycle
        clr_in();
        set_rd_all(5);
        wr_en[SE] = 1'b1;
        wr_addr[SE*AW +: AW] = 5'd9;
        wr_data[SE*DW +: DW] = 16'hCAFE;
        swap_req = 1'b1;
        step_and_check(1'b1);
        check("swapcyc_rd_lit", rd_data[E*DW +: DW], 16'h1234);
        check("swapcyc_bank_lit", rd_bank, 1);
        clr_in();
        rd_en = 1'b1;
        rd_addr[SE*AW +: AW] = 5'd9;
        step_and_check(1'b1);
        check("swapcyc_wr_lit", rd_data[SE*DW +: DW], 16'hCAFE);

        // Out-of-range write on channel 0 is dropped, error sticks
        clr_in();
        wr_en[C0] = 1'b1;
        wr_addr[C0*AW +: AW] = 5'd16;
        wr_data[C0*DW +: DW] = 16'hBEEF;
        step_and_check(1'b1);
        check("oob_err_lit", err_oob, 1);
        clr_in();
        swap_req = 1'b1;
        step_and_check(1'b1);
        clr_in();
        for (int a = 0; a < DP; a++) begin
            set_rd_all(a);
            step_and_check(1'b1);
        end

        // Randomized RUN traffic, including occasional out-of-range addresses
        for (int i = 0; i < 300; i++) begin
            clr_in();
            rd_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < NC; c++) begin
                rd_addr[c*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 31))
                                                                  : AW'($urandom_range(0, 15));
                wr_addr[c*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 31))
                                                                  : AW'($urandom_range(0, 15));
                wr_data[c*DW +: DW] = DW'($urandom);
            end
            wr_en    = NC'($urandom);
            swap_req = ($urandom_range(0, 3) == 0);
            step_and_check(1'b1);
        end
        check("err_sticky", err_oob, 1);

        // Reset in the middle of a fill
        clr_in();
        run = 1'b0;
        set_init(16'h0200);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (7) tick();
        check("midfill_ready", ready, 0);
        rst = 1'b0;
        tick();
        check("rerst_err", err_oob, 0);
        check("rerst_cnt", step_count, 0);
        check("rerst_cur", cur_bank, 0);
        rst = 1'b1;
        wait_ready("refill_cycles");
        model_fill();
        m_cur = 0; m_steps = 0; m_err = 1'b0;

        run = 1'b1;
        step_and_check(1'b0);
        swap_req = 1'b1;
        repeat (3) step_and_check(1'b1);
        check("three_swaps_cnt", step_count, 3);
        check("three_swaps_cur", cur_bank, 1);
        clr_in();
        for (int a = 0; a < DP; a += 5) begin
            set_rd_all(a);
            step_and_check(1'b1);
        end
        check("refill_lit", rd_data[NW*DW +: DW], 16'h0208);

        // run falls with a swap in the same cycle: swap honoured, then IDLE ignores swaps
        clr_in();
        run = 1'b0;
        swap_req = 1'b1;
        step_and_check(1'b1);
        check("run_off_swap_cnt", step_count, 4);
        step_and_check(1'b0);
        check("idle_swap_ignored", step_count, 4);

        // fill_start and run together in IDLE: fill wins, then RUN
        clr_in();
        set_init(16'h0300);
        fill_start = 1'b1;
        run = 1'b1;
        tick();
        check("fill_start_ready", ready, 0);
        fill_start = 1'b0;
        wait_ready("fill_start_cycles");
        model_fill();
        step_and_check(1'b0);
        swap_req = 1'b1;
        step_and_check(1'b1);
        check("after_fill_run_cnt", step_count, 5);
        clr_in();
        set_rd_all(15);
        step_and_check(1'b1);
        check("fill_start_lit", rd_data[C0*DW +: DW], 16'h0300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
